// File: rtl/thermocouple_pkg.sv
// Shared types and frame field positions for the multi-channel thermocouple scanner.
package thermocouple_pkg;

    typedef enum logic [2:0] {
        PWRUP   = 3'd0,
        REQ     = 3'd1,
        BUSY    = 3'd2,
        CAPTURE = 3'd3,
        NEXT    = 3'd4,
        GAP     = 3'd5
    } state_t;

    // Bit positions inside a MAX31855-style 32-bit frame
    localparam int unsigned TC_MSB = 31;
    localparam int unsigned TC_LSB = 18;
    localparam int unsigned JT_MSB = 15;
    localparam int unsigned JT_LSB = 4;
    localparam int unsigned FLT_OC = 16;

    localparam int unsigned TC_W  = 14;
    localparam int unsigned JT_W  = 12;
    localparam int unsigned FLT_W = 4;

    typedef struct packed {
        logic [TC_W-1:0]  tc;
        logic [JT_W-1:0]  jt;
        logic [FLT_W-1:0] flt;
    } tc_frame_t;

endpackage

// File: rtl/tc_channel_reg.sv
// Per-channel result registers: temperature, junction, fault, valid and timeout flags.
// Optional build macro TC_FAULT_HOLD_EN keeps the last good temperatures on faulted frames.
module tc_channel_reg
    import thermocouple_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             timeout,
    input  tc_frame_t        frame,
    output logic [TC_W-1:0]  tc,
    output logic [JT_W-1:0]  jt,
    output logic [FLT_W-1:0] flt,
    output logic             valid,
    output logic             timed_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc        <= '0;
            jt        <= '0;
            flt       <= '0;
            valid     <= 1'b0;
            timed_out <= 1'b0;
        end else if (load) begin
`ifdef TC_FAULT_HOLD_EN
            // Faulted frames only accumulate fault flags; a clean frame refreshes everything
            if (frame.flt != '0) begin
                flt <= flt | frame.flt;
            end else begin
                tc  <= frame.tc;
                jt  <= frame.jt;
                flt <= frame.flt;
            end
`else
            tc  <= frame.tc;
            jt  <= frame.jt;
            flt <= frame.flt;
`endif
            valid     <= 1'b1;
            timed_out <= 1'b0;
        end else if (timeout) begin
            timed_out <= 1'b1;
        end
    end

endmodule

// File: rtl/thermocouple_scanner.sv
// Round-robin scanner of NCH thermocouple converters through one shared SPI master.
// Build macro TC_FAULT_HOLD_EN selects fault-hold behaviour in the channel registers.
module thermocouple_scanner
    import thermocouple_pkg::*;
#(
    parameter int unsigned NCH            = 4,
    parameter int unsigned PWRUP_CYCLES   = 300,
    parameter int unsigned GAP_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_not_busy,
    input  logic [31:0]          spi_rx_data,
    output logic                 spi_ena,
    output logic [CHW-1:0]       spi_ch,
    output logic [NCH*TC_W-1:0]  tc_temp_data,
    output logic [NCH*JT_W-1:0]  junction_temp_data,
    output logic [NCH*FLT_W-1:0] fault_bits,
    output logic [NCH-1:0]       ch_valid,
    output logic [NCH-1:0]       ch_timeout,
    output logic                 scan_done
);

    localparam int unsigned CNT_MAX0 = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic             scan_done_d;
    logic             spi_ena_d;
    logic             load_c;
    logic             timeout_c;
    tc_frame_t        frame_c;
    logic             unused_rsvd;

    assign frame_c     = {spi_rx_data[TC_MSB:TC_LSB], spi_rx_data[JT_MSB:JT_LSB],
                          spi_rx_data[FLT_OC], spi_rx_data[2:0]};
    assign unused_rsvd = ^{spi_rx_data[17], spi_rx_data[3]};
    assign spi_ch      = ch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PWRUP;
            cnt_q     <= '0;
            ch_q      <= '0;
            spi_ena   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            spi_ena   <= spi_ena_d;
            scan_done <= scan_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        scan_done_d = 1'b0;
        load_c      = 1'b0;
        timeout_c   = 1'b0;
        case (state_q)
            PWRUP: begin
                if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                // A busy response wins over a coincident timeout
                if (!spi_not_busy) begin
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUSY: begin
                if (spi_not_busy) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                load_c  = 1'b1;
                state_d = NEXT;
            end
            NEXT: begin
                if (ch_q == CHW'(NCH - 1)) begin
                    ch_d        = '0;
                    scan_done_d = 1'b1;
                end else begin
                    ch_d = ch_q + CHW'(1);
                end
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = REQ;
            end
        endcase
        spi_ena_d = (state_d == REQ);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tc_channel_reg u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load_c && (ch_q == CHW'(i))),
            .timeout   (timeout_c && (ch_q == CHW'(i))),
            .frame     (frame_c),
            .tc        (tc_temp_data[i*TC_W +: TC_W]),
            .jt        (junction_temp_data[i*JT_W +: JT_W]),
            .flt       (fault_bits[i*FLT_W +: FLT_W]),
            .valid     (ch_valid[i]),
            .timed_out (ch_timeout[i])
        );
    end

endmodule

// File: tb/tb_thermocouple_scanner.sv
// Randomized bench for thermocouple_scanner against a transaction-level reference model.
module tb_thermocouple_scanner;

    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_not_busy;
    logic [31:0]       spi_rx_data;
    logic              spi_ena;
    logic [CHW-1:0]    spi_ch;
    logic [NCH*14-1:0] tc_temp_data;
    logic [NCH*12-1:0] junction_temp_data;
    logic [NCH*4-1:0]  fault_bits;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_timeout;
    logic              scan_done;

    thermocouple_scanner #(
        .NCH(NCH), .PWRUP_CYCLES(300), .GAP_CYCLES(100), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .spi_not_busy       (spi_not_busy),
        .spi_rx_data        (spi_rx_data),
        .spi_ena            (spi_ena),
        .spi_ch             (spi_ch),
        .tc_temp_data       (tc_temp_data),
        .junction_temp_data (junction_temp_data),
        .fault_bits         (fault_bits),
        .ch_valid           (ch_valid),
        .ch_timeout         (ch_timeout),
        .scan_done          (scan_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [13:0] m_tc  [NCH];
    logic [11:0] m_jt  [NCH];
    logic [3:0]  m_flt [NCH];
    logic        m_val [NCH];
    logic        m_to  [NCH];
    int m_ch;
    int m_scans;
    int scan_cnt = 0;
    int n_checks = 0;
    int n_errors = 0;

    always @(negedge clk) if (scan_done === 1'b1) scan_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_tc[i] = '0; m_jt[i] = '0; m_flt[i] = '0; m_val[i] = 1'b0; m_to[i] = 1'b0;
        end
        m_ch = 0;
    endtask

    task automatic model_capture(input logic [31:0] f);
        logic [3:0] fl;
        fl = {f[16], f[2:0]};
`ifdef TC_FAULT_HOLD_EN
        if (fl != 4'd0) begin
            m_flt[m_ch] = m_flt[m_ch] | fl;
        end else begin
            m_tc[m_ch] = f[31:18]; m_jt[m_ch] = f[15:4]; m_flt[m_ch] = fl;
        end
`else
        m_tc[m_ch] = f[31:18]; m_jt[m_ch] = f[15:4]; m_flt[m_ch] = fl;
`endif
        m_val[m_ch] = 1'b1;
        m_to[m_ch]  = 1'b0;
    endtask

    task automatic model_advance();
        m_ch = m_ch + 1;
        if (m_ch == NCH) begin
            m_ch = 0;
            m_scans++;
        end
    endtask

    task automatic check_all();
        logic [NCH*14-1:0] e_tc;
        logic [NCH*12-1:0] e_jt;
        logic [NCH*4-1:0]  e_flt;
        logic [NCH-1:0]    e_val, e_to;
        for (int i = 0; i < NCH; i++) begin
            e_tc[i*14 +: 14] = m_tc[i];
            e_jt[i*12 +: 12] = m_jt[i];
            e_flt[i*4 +: 4]  = m_flt[i];
            e_val[i]         = m_val[i];
            e_to[i]          = m_to[i];
        end
        chk("tc_temp_data", 64'(tc_temp_data), 64'(e_tc));
        chk("junction_temp_data", 64'(junction_temp_data), 64'(e_jt));
        chk("fault_bits", 64'(fault_bits), 64'(e_flt));
        chk("ch_valid", 64'(ch_valid), 64'(e_val));
        chk("ch_timeout", 64'(ch_timeout), 64'(e_to));
        chk("spi_ch", 64'(spi_ch), 64'(m_ch));
        chk("scan_count", 64'(scan_cnt), 64'(m_scans));
    endtask

    task automatic measure_pwrup(input string tag);
        int n;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (spi_ena) break;
        end
        chk(tag, 64'(n), 64'd300);
    endtask

    // Entered with spi_ena sampled high; leaves at the first sample of the next request
    task automatic txn_timeout();
        int hi, lo;
        check_all();
        hi = 1;
        while (hi < 200) begin
            @(negedge clk);
            if (!spi_ena) break;
            hi++;
        end
        chk("req_len", 64'(hi), 64'd64);
        m_to[m_ch] = 1'b1;
        model_advance();
        lo = 1;
        while (lo < 300) begin
            @(negedge clk);
            if (spi_ena) break;
            lo++;
        end
        chk("gap_after_timeout", 64'(lo), 64'd101);
    endtask

    task automatic txn_resp(input logic [31:0] f, input int d, input int h);
        int n;
        check_all();
        repeat (d) @(negedge clk);
        chk("ena_hold", 64'(spi_ena), 64'd1);
        spi_not_busy = 1'b0;
        spi_rx_data  = f;
        @(negedge clk);
        chk("ena_drop", 64'(spi_ena), 64'd0);
        repeat (h - 1) @(negedge clk);
        spi_not_busy = 1'b1;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (spi_ena) break;
        end
        chk("gap_after_frame", 64'(n), 64'd103);
        model_capture(f);
        model_advance();
        spi_rx_data = $urandom();
    endtask

    function automatic logic [31:0] clean_frame();
        return $urandom() & ~32'h0001_0007;
    endfunction

    function automatic logic [31:0] fault_frame();
        logic [3:0] fb;
        fb = 4'($urandom_range(1, 15));
        return clean_frame() | {15'd0, fb[3], 13'd0, fb[2:0]};
    endfunction

    initial begin
        rst          = 1'b1;
        spi_not_busy = 1'b1;
        spi_rx_data  = '0;
        m_scans      = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("rst_spi_ena", 64'(spi_ena), 64'd0);
        chk("rst_scan_done", 64'(scan_done), 64'd0);
        rst = 1'b0;
        measure_pwrup("pwrup_len");

        // Unanswered request on ch0, then the reference frame on ch1
        txn_timeout();
        txn_resp(32'h0640_1910, 2, 34);
        chk("ch1_tc", 64'(tc_temp_data[27:14]), 64'h190);
        chk("ch1_jt", 64'(junction_temp_data[23:12]), 64'h191);
        chk("ch1_flt", 64'(fault_bits[7:4]), 64'h0);
        chk("ch1_valid", 64'(ch_valid[1]), 64'd1);

        // Timeout on ch2, finish the scan, then recover ch2 on the next scan
        txn_timeout();
        chk("ch2_timeout_set", 64'(ch_timeout[2]), 64'd1);
        txn_resp(clean_frame(), $urandom_range(0, 3), $urandom_range(1, 40));
        for (int i = 0; i < NCH; i++)
            txn_resp(clean_frame(), $urandom_range(0, 3), $urandom_range(1, 40));
        chk("ch2_timeout_clr", 64'(ch_timeout[2]), 64'd0);
        chk("ch2_valid", 64'(ch_valid[2]), 64'd1);

        // Open-circuit + rx[0] fault after clean frames on every channel
        for (int i = 0; i < NCH; i++)
            txn_resp(clean_frame() | 32'h0001_0001, $urandom_range(0, 3), $urandom_range(1, 40));
        chk("fault_1001", 64'(fault_bits), 64'h9999);

        for (int i = 0; i < 16; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)
                txn_timeout();
            else if (r < 4)
                txn_resp(fault_frame(), $urandom_range(0, 3), $urandom_range(1, 40));
            else
                txn_resp(clean_frame(), $urandom_range(0, 3), $urandom_range(1, 40));
        end

        // Asynchronous reset in the middle of a busy transaction
        check_all();
        spi_not_busy = 1'b0;
        spi_rx_data  = clean_frame();
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_spi_ena", 64'(spi_ena), 64'd0);
        chk("arst_spi_ch", 64'(spi_ch), 64'd0);
        chk("arst_tc", 64'(tc_temp_data), 64'd0);
        chk("arst_jt", 64'(junction_temp_data), 64'd0);
        chk("arst_flt", 64'(fault_bits), 64'd0);
        chk("arst_valid", 64'(ch_valid), 64'd0);
        chk("arst_timeout", 64'(ch_timeout), 64'd0);
        chk("arst_scan_done", 64'(scan_done), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst          = 1'b0;
        spi_not_busy = 1'b1;
        measure_pwrup("pwrup_after_rst");
        txn_resp(clean_frame(), 1, 10);
        check_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
